// File: rtl/seq_bitscan_encoder.sv
// Serialises a multi-hot request vector into a stream of set-bit indices.
// Optional beats-remaining output enabled by defining SEQ_BITSCAN_CNT_EN.
module seq_bitscan_encoder #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [N-1:0] I,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] Y,
    output logic         V,
    output logic         last,
    output logic         out_valid,
`ifdef SEQ_BITSCAN_CNT_EN
    output logic [W:0]   cnt,
`endif
    input  logic         out_ready
);

    localparam int CW = W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         r_state;
    logic [N-1:0]   r_pend;

    logic [W-1:0]   w_idx;
    logic [N-1:0]   w_onehot;
    logic [CW-1:0]  w_cnt;
    logic           w_busy;
    logic           w_last;

    function automatic int unsigned scan_pos(input int unsigned k);
        return LSB_FIRST ? k : (N - 1 - k);
    endfunction

    // Scan in priority order; the first set bit found wins, popcount in the same pass.
    always_comb begin
        w_idx    = '0;
        w_onehot = '0;
        w_cnt    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (r_pend[W'(scan_pos(k))] && (w_onehot == '0)) begin
                w_idx                     = W'(scan_pos(k));
                w_onehot[W'(scan_pos(k))] = 1'b1;
            end
            w_cnt = w_cnt + CW'(r_pend[k]);
        end
    end

    assign w_busy    = (r_state == BUSY);
    assign w_last    = (w_cnt <= CW'(1));

    assign in_ready  = rst_n && (r_state == IDLE) && !clr;
    assign out_valid = w_busy;
    assign Y         = w_busy ? w_idx : '0;
    assign V         = w_busy && (r_pend != '0);
    assign last      = w_busy && w_last;
`ifdef SEQ_BITSCAN_CNT_EN
    assign cnt       = w_busy ? w_cnt : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
        end else if (clr) begin
            r_state <= IDLE;
            r_pend  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pend  <= I;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        r_pend <= r_pend & ~w_onehot;
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pend  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bitscan_encoder.sv
// Scoreboard bench for seq_bitscan_encoder: N=8 LSB-first, N=8 MSB-first, N=5 LSB-first.
// Checks cnt as well when built with SEQ_BITSCAN_CNT_EN.
module tb_seq_bitscan_encoder;

    typedef struct {
        logic [2:0] y;
        logic       v;
        logic       last;
        logic [3:0] cnt;
    } beat_t;
    typedef beat_t bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr8, clr5;
    logic [7:0] i8;
    logic [4:0] i5;
    logic       v8, v5, or8, or5;

    logic       ir8a, ir8b, ir5, ov8a, ov8b, ov5;
    logic [2:0] y8a, y8b, y5;
    logic       vv8a, vv8b, vv5, l8a, l8b, l5;
    logic [3:0] c8a, c8b, c5;

    beat_t      q[3][$];
    int         pops[3];
    bit         acc[3];
    int         n_vec = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    seq_bitscan_encoder #(.N(8), .LSB_FIRST(1'b1)) dut8a (
        .clk(clk), .rst_n(rst_n), .clr(clr8), .I(i8), .in_valid(v8), .in_ready(ir8a),
        .Y(y8a), .V(vv8a), .last(l8a), .out_valid(ov8a),
`ifdef SEQ_BITSCAN_CNT_EN
        .cnt(c8a),
`endif
        .out_ready(or8));

    seq_bitscan_encoder #(.N(8), .LSB_FIRST(1'b0)) dut8b (
        .clk(clk), .rst_n(rst_n), .clr(clr8), .I(i8), .in_valid(v8), .in_ready(ir8b),
        .Y(y8b), .V(vv8b), .last(l8b), .out_valid(ov8b),
`ifdef SEQ_BITSCAN_CNT_EN
        .cnt(c8b),
`endif
        .out_ready(or8));

    seq_bitscan_encoder #(.N(5), .LSB_FIRST(1'b1)) dut5 (
        .clk(clk), .rst_n(rst_n), .clr(clr5), .I(i5), .in_valid(v5), .in_ready(ir5),
        .Y(y5), .V(vv5), .last(l5), .out_valid(ov5),
`ifdef SEQ_BITSCAN_CNT_EN
        .cnt(c5),
`endif
        .out_ready(or5));

`ifndef SEQ_BITSCAN_CNT_EN
    assign c8a = '0;
    assign c8b = '0;
    assign c5  = '0;
`endif

    function automatic bq_t build(input logic [7:0] vec, input int n, input bit lsb);
        bq_t   r;
        beat_t b;
        int    idx;
        if (vec == 8'd0) begin
            b.y = 3'd0; b.v = 1'b0; b.last = 1'b1; b.cnt = 4'd0;
            r.push_back(b);
            return r;
        end
        while (vec != 8'd0) begin
            idx = -1;
            for (int k = 0; k < n; k++)
                if (vec[k] && (!lsb || idx < 0)) idx = k;
            b.y    = 3'(idx);
            b.v    = 1'b1;
            b.cnt  = 4'($countones(vec));
            b.last = (b.cnt == 4'd1);
            r.push_back(b);
            vec[idx] = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input int d, input string tag, input logic ov, input logic [2:0] y,
                         input logic v, input logic lst, input logic [3:0] c, input logic ir,
                         input logic ordy, input logic clrs, input logic ivld,
                         input logic [7:0] vec, input int n, input bit lsb);
        beat_t e;
        bq_t   nb;
        logic  exp_ir;
        logic  exp_ov;
        exp_ir = rst_n && !clrs && (q[d].size() == 0);
        exp_ov = (q[d].size() != 0);
        n_vec++;
        assert (ir === exp_ir) else begin
            n_fail++; $error("FAIL %s.in_ready got %b want %b", tag, ir, exp_ir);
        end
        n_vec++;
        assert (ov === exp_ov) else begin
            n_fail++; $error("FAIL %s.out_valid got %b want %b", tag, ov, exp_ov);
        end
        if (exp_ov) begin
            e = q[d][0];
            n_vec++;
            assert ({y, v, lst} === {e.y, e.v, e.last}) else begin
                n_fail++;
                $error("FAIL %s.beat got Y=%0d V=%b last=%b want Y=%0d V=%b last=%b",
                       tag, y, v, lst, e.y, e.v, e.last);
            end
`ifdef SEQ_BITSCAN_CNT_EN
            n_vec++;
            assert (c === e.cnt) else begin
                n_fail++; $error("FAIL %s.cnt got %0d want %0d", tag, c, e.cnt);
            end
`endif
            if (ordy) begin
                void'(q[d].pop_front());
                pops[d]++;
            end
        end else begin
            n_vec++;
            assert ({y, v, lst, c} === 6'b0) else begin
                n_fail++; $error("FAIL %s.idle got Y=%0d V=%b last=%b cnt=%0d want 0", tag, y, v, lst, c);
            end
        end
        if (clrs) q[d].delete();
        if (ivld && exp_ir) begin
            nb = build(vec, n, lsb);
            foreach (nb[k]) q[d].push_back(nb[k]);
            acc[d] = 1'b1;
        end
    endtask

    task automatic check_zero(input string tag, input logic ov, input logic ir, input logic [2:0] y,
                              input logic v, input logic lst, input logic [3:0] c);
        n_vec++;
        assert ({ov, ir, y, v, lst, c} === 11'b0) else begin
            n_fail++;
            $error("FAIL %s.reset got ov=%b ir=%b Y=%0d V=%b last=%b cnt=%0d want all 0",
                   tag, ov, ir, y, v, lst, c);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check(0, "lsb8", ov8a, y8a, vv8a, l8a, c8a, ir8a, or8, clr8, v8, i8, 8, 1'b1);
        check(1, "msb8", ov8b, y8b, vv8b, l8b, c8b, ir8b, or8, clr8, v8, i8, 8, 1'b0);
        check(2, "n5",   ov5,  y5,  vv5,  l5,  c5,  ir5,  or5, clr5, v5, {3'b0, i5}, 5, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] vec);
        acc[d] = 1'b0;
        if (d == 2) begin i5 = vec[4:0]; v5 = 1'b1; end
        else begin i8 = vec; v8 = 1'b1; end
        for (int k = 0; k < 20 && !acc[d]; k++) tick();
        v8 = 1'b0;
        v5 = 1'b0;
        if (!acc[d]) begin
            n_vec++;
            assert (acc[d] === 1'b1) else begin
                n_fail++; $error("FAIL accept.timeout got %b want 1", acc[d]);
            end
        end
    endtask

    task automatic drain(input int d);
        for (int k = 0; k < 40 && q[d].size() != 0; k++) tick();
        n_vec++;
        assert (q[d].size() === 0) else begin
            n_fail++; $error("FAIL drain.timeout got %0d pending want 0", q[d].size());
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; clr8 = 1'b0; clr5 = 1'b0;
        i8 = '0; i5 = '0; v8 = 1'b0; v5 = 1'b0; or8 = 1'b1; or5 = 1'b1;
        #2;
        check_zero("lsb8", ov8a, ir8a, y8a, vv8a, l8a, c8a);
        check_zero("msb8", ov8b, ir8b, y8b, vv8b, l8b, c8b);
        check_zero("n5",   ov5,  ir5,  y5,  vv5,  l5,  c5);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        send(0, 8'b1010_0110);
        drain(0);
        send(0, 8'h00);
        drain(0);

        or8 = 1'b0;
        send(0, 8'b0001_1000);
        repeat (3) tick();
        or8 = 1'b1;
        drain(0);

        send(0, 8'hFF);
        tick();
        tick();
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        tick();
        send(0, 8'h80);
        drain(0);

        send(0, 8'hFF);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("lsb8", ov8a, ir8a, y8a, vv8a, l8a, c8a);
        check_zero("msb8", ov8b, ir8b, y8b, vv8b, l8b, c8b);
        for (int d = 0; d < 3; d++) q[d].delete();
        @(posedge clk); #1;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        send(0, 8'h80);
        drain(0);

        send(2, 8'b0001_0101);
        drain(2);
        for (int vec = 0; vec < 32; vec++) begin
            int exp_beats;
            exp_beats = ($countones(vec) > 1) ? $countones(vec) : 1;
            pops[2] = 0;
            send(2, 8'(vec));
            drain(2);
            n_vec++;
            assert (pops[2] === exp_beats) else begin
                n_fail++; $error("FAIL n5.beats[%0d] got %0d want %0d", vec, pops[2], exp_beats);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_bitscan_encoder.md
Name: seq_bitscan_encoder

Overview:
- Parametrised, handshaked successor to the fixed 4-to-2 encoder with valid bit.
- Accepts an N-bit request vector and emits the index of every set bit, one index per output beat, in priority order.
- Each beat carries a valid bit (V) and a last flag.
- Used wherever a multi-hot request word must be serialised into a stream of binary indices, e.g. interrupt or request drain logic.

Parameters:
- N, 8, width of the request vector; N >= 2; N need not be a power of two.
- LSB_FIRST, 1, 1 = lowest set index emitted first; 0 = highest set index emitted first.
- W (localparam, not overridable), $clog2(N), width of the index output Y.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous abort; drops any pending work.
- I  input  N  request vector.
- in_valid  input  1  I is valid this cycle.
- in_ready  output  1  block can accept I this cycle.
- Y  output  W  binary index of the current set bit.
- V  output  1  1 = Y refers to a real set bit; 0 = the input vector was all zeros.
- last  output  1  current beat is the final beat for the accepted vector.
- out_valid  output  1  Y/V/last valid this cycle.
- out_ready  input  1  consumer accepts the beat this cycle.

Behaviour:
- State register: IDLE, BUSY. Data register: pend[N-1:0].
- Reset (rst_n low, asynchronous):
  - state = IDLE, pend = 0.
  - Outputs: in_ready = 0 while rst_n is low, then 1 from the first cycle after release; out_valid = 0, Y = 0, V = 0, last = 0.
- in_ready = (state == IDLE) && !clr. Combinational from state and clr only; never depends on in_valid.
- Accept in IDLE (in_valid && in_ready):
  - pend <= I; state <= BUSY.
  - The first beat is presented the cycle after acceptance: latency 1.
- While BUSY:
  - out_valid = 1.
  - Y = index of lowest set bit of pend (LSB_FIRST = 1) or highest set bit (LSB_FIRST = 0).
  - V = |pend.
  - last = (popcount(pend) <= 1).
  - Y, V and last are functions of pend only, so they stay stable while out_valid && !out_ready.
- Pop (out_valid && out_ready):
  - pend <= pend with bit Y cleared.
  - If last, state <= IDLE.
  - Throughput: one index per cycle while out_ready is held high.
- Zero vector: accepting I == 0 produces exactly one beat with Y = 0, V = 0, last = 1, then returns to IDLE.
- Single-bit vector: exactly one beat with V = 1, last = 1. This matches the legacy one-hot encoding.
- Back-to-back inputs: there is no overlap. After the last pop the block spends one cycle in IDLE before it can present a new vector's first beat, so the minimum spacing is popcount + 1 cycles per vector.
- IDLE outputs: out_valid = 0, Y = 0, V = 0, last = 0.
- clr (synchronous):
  - Next edge forces state = IDLE and pend = 0, regardless of any other input.
  - A beat popped in the same cycle as clr counts as consumed; no further beats follow.
  - clr in IDLE blocks acceptance that cycle.
- Reset mid-vector: all pending indices are discarded immediately; no beat appears after reset release until a new vector is accepted.
- No X propagation: Y is always driven to a defined value.

Optional Feature:
- Macro: SEQ_BITSCAN_CNT_EN.
- Defined:
  - Adds output port cnt, width W+1.
  - While BUSY, cnt = popcount(pend), i.e. beats remaining including the current one.
  - In IDLE and during reset, cnt = 0.
  - For a zero vector, cnt = 0 while its single V = 0 beat is presented.
- Not defined: port cnt and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then N = 8, LSB_FIRST = 1, I = 8'b1010_0110, out_ready = 1 -> beats Y = 1, 2, 5, 7 on 4 consecutive cycles; V = 1 on all; last = 1 only on Y = 7; in_ready returns to 1 the cycle after the last pop.
- Same vector with LSB_FIRST = 0 -> Y = 7, 5, 2, 1; last on Y = 1.
- I = 0 -> single beat Y = 0, V = 0, last = 1; then IDLE.
- Backpressure: I = 8'b0001_1000, out_ready low for 3 cycles then high -> Y = 3 held stable with out_valid = 1 for 3 cycles, then Y = 3, Y = 4 (last) on successive cycles.
- Abort: I = 8'hFF, pop 2 beats (Y = 0, 1), assert clr together with the Y = 2 pop -> out_valid = 0 the next cycle, in_ready = 1; a new I = 8'h80 then yields a single beat Y = 7, last = 1. Repeat the sequence using rst_n low mid-vector instead of clr -> outputs go to 0 asynchronously.
- SEQ_BITSCAN_CNT_EN defined, N = 5, I = 5'b10101 -> cnt = 3, 2, 1 alongside Y = 0, 2, 4; cnt = 0 in IDLE. Also sweep every 5-bit vector and check the beat count equals max(1, popcount).
